// File: rtl/data_ram_mmio_pkg.sv
// Shared constants and types for the data RAM with keyboard MMIO ports.
// The key FIFO is only built when DATA_RAM_KEY_FIFO_EN is defined.
package data_ram_mmio_pkg;

  localparam logic [12:0] KEY_DATA_ADDR_DEF = 13'h0310;
  localparam logic [12:0] KEY_STAT_ADDR_DEF = 13'h0314;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;

  typedef struct packed {
    logic [15:0] rsvd;
    logic [7:0]  count;
    logic [4:0]  pad;
    logic        ovf;
    logic        full;
    logic        empty;
  } key_stat_t;

  function automatic logic [31:0] lane_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Keyboard FIFO: circular buffer with combinational head and occupancy count.
// A push while full succeeds only when a real pop happens in the same cycle.
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  buf_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_pop;
  logic          do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = buf_q[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) buf_q[wr_ptr] <= din;
  end

endmodule

// File: rtl/data_ram_mmio.sv
// Word RAM with byte-lane stores and write-through loads, plus keyboard
// MMIO ports; define DATA_RAM_KEY_FIFO_EN to build the key FIFO.
module data_ram_mmio
  import data_ram_mmio_pkg::*;
#(
  parameter int ADDR_W         = 13,
  parameter int DEPTH_WORDS    = 2048,
  parameter int KEY_FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] KEY_DATA_ADDR = ADDR_W'(KEY_DATA_ADDR_DEF),
  parameter logic [ADDR_W-1:0] KEY_STAT_ADDR = ADDR_W'(KEY_STAT_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_write_enable,
  input  logic              ram_read_enable,
  input  logic [3:0]        ram_byte_en,
  input  logic [31:0]       ram_write_data,
  output logic [31:0]       ram_read_data,
  input  logic [7:0]        key_data,
  input  logic              key_valid,
  output logic              key_ready
);

  localparam int IW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [IW-1:0] widx;
  logic [31:0]   old_word;
  logic [31:0]   ram_word;
  logic          ram_we;
  logic          unused_lo;

  assign widx      = ram_addr[IW+1:2];
  assign old_word  = mem[widx];
  assign ram_word  = ram_write_enable
                   ? lane_merge(old_word, ram_write_data, ram_byte_en)
                   : old_word;
  assign unused_lo = ^ram_addr[1:0];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_byte_en[i]) mem[widx][8*i +: 8] <= ram_write_data[8*i +: 8];
      end
    end
  end

`ifdef DATA_RAM_KEY_FIFO_EN

  localparam int CW = $clog2(KEY_FIFO_DEPTH) + 1;

  logic          kd_hit;
  logic          ks_hit;
  logic          pop_req;
  logic          ovf_clr;
  logic          ovf;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  key_stat_t     stat;

  assign kd_hit  = ram_addr[ADDR_W-1:2] == KEY_DATA_ADDR[ADDR_W-1:2];
  assign ks_hit  = ram_addr[ADDR_W-1:2] == KEY_STAT_ADDR[ADDR_W-1:2];
  assign pop_req = ram_read_enable && kd_hit;
  assign ram_we  = ram_write_enable && !kd_hit && !ks_hit;
  assign ovf_clr = ram_write_enable && ks_hit && ram_byte_en[0]
                 && ram_write_data[STAT_OVF];

  // a full FIFO still takes a key when the CPU pops in the same cycle
  assign key_ready = !full || (pop_req && !empty);

  key_fifo #(
    .DEPTH (KEY_FIFO_DEPTH),
    .W     (8)
  ) u_key_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (key_valid),
    .pop   (pop_req),
    .din   (key_data),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (key_valid && !key_ready) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  always_comb begin
    stat       = '0;
    stat.count = 8'(count);
    stat.ovf   = ovf;
    stat.full  = full;
    stat.empty = empty;
  end

  always_comb begin
    ram_read_data = ram_word;
    unique case (1'b1)
      kd_hit:  ram_read_data = empty ? 32'h0 : {24'h0, head};
      ks_hit:  ram_read_data = stat;
      default: ram_read_data = ram_word;
    endcase
  end

`else

  logic unused_key;

  assign ram_we        = ram_write_enable;
  assign ram_read_data = ram_word;
  assign key_ready     = 1'b1;
  assign unused_key    = ^{key_data, key_valid, ram_read_enable, reset};

`endif

endmodule

// File: tb/tb_data_ram_mmio.sv
// Scoreboard bench for data_ram_mmio: driver queues model expectations,
// a negedge monitor pops and compares read data and key_ready.
module tb_data_ram_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] ram_addr;
  logic        ram_write_enable;
  logic        ram_read_enable;
  logic [3:0]  ram_byte_en;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic [7:0]  key_data;
  logic        key_valid;
  logic        key_ready;

  always #5 clk = ~clk;

  data_ram_mmio dut (
    .clk              (clk),
    .reset            (reset),
    .ram_addr         (ram_addr),
    .ram_write_enable (ram_write_enable),
    .ram_read_enable  (ram_read_enable),
    .ram_byte_en      (ram_byte_en),
    .ram_write_data   (ram_write_data),
    .ram_read_data    (ram_read_data),
    .key_data         (key_data),
    .key_valid        (key_valid),
    .key_ready        (key_ready)
  );

  typedef struct {
    string       name;
    logic [31:0] rd;
    bit          vr;
    logic        kr;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk = 0;
  logic [31:0] mem_m [int];
  logic [7:0]  fq[$];
  bit          ovf_m = 0;
  logic [12:0] kd_addr = 13'h0310;
  logic [12:0] ks_addr = 13'h0314;

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n,
                                        logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic step(string nm, bit rst, logic [12:0] a, bit w, bit r,
                      logic [3:0] b, logic [31:0] d, bit kv,
                      logic [7:0] kd, bit lit = 0, logic [31:0] lv = 0);
    exp_t        e;
    int          wi;
    int          sz;
    bit          kdh;
    bit          ksh;
    bit          known;
    bit          popped;
    bit          pushed;
    bit          clr;
    logic [31:0] old;
    @(posedge clk);
    #1;
    reset = rst; ram_addr = a; ram_write_enable = w; ram_read_enable = r;
    ram_byte_en = b; ram_write_data = d; key_valid = kv; key_data = kd;
    wi = int'(a[12:2]);
    sz = fq.size();
`ifdef DATA_RAM_KEY_FIFO_EN
    kdh = (a[12:2] == kd_addr[12:2]);
    ksh = (a[12:2] == ks_addr[12:2]);
`else
    kdh = 0;
    ksh = 0;
`endif
    known = mem_m.exists(wi);
    old   = known ? mem_m[wi] : 32'h0;
    e.name = nm;
    e.rd   = w ? merge(old, d, b) : old;
    e.vr   = known || (w && b == 4'hF);
    if (kdh) begin
      e.rd = (sz > 0) ? {24'h0, fq[0]} : 32'h0;
      e.vr = 1;
    end else if (ksh) begin
      e.rd = {16'h0, 8'(sz), 5'h0, ovf_m, sz == 8, sz == 0};
      e.vr = 1;
    end
`ifdef DATA_RAM_KEY_FIFO_EN
    e.kr = (sz < 8) || (r && kdh && sz > 0);
`else
    e.kr = 1'b1;
`endif
    if (lit) begin
      e.rd = lv;
      e.vr = 1;
    end
    sbq.push_back(e);
    chk = 1;
    if (w && !kdh && !ksh && (known || b == 4'hF))
      mem_m[wi] = merge(old, d, b);
`ifdef DATA_RAM_KEY_FIFO_EN
    if (rst) begin
      fq.delete();
      ovf_m = 0;
    end else begin
      popped = r && kdh && sz > 0;
      pushed = kv && (sz < 8 || popped);
      clr    = w && ksh && b[0] && d[2];
      if (popped) void'(fq.pop_front());
      if (pushed) fq.push_back(kd);
      if (kv && !pushed) ovf_m = 1;
      else if (clr) ovf_m = 0;
    end
`endif
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL no_expectation: output seen with empty scoreboard");
      end else begin
        e = sbq.pop_front();
        if (e.vr) begin
          n_cmp++;
          if (ram_read_data !== e.rd) begin
            n_bad++;
            $display("FAIL %s rd: got %h want %h", e.name, ram_read_data, e.rd);
          end
        end
        n_cmp++;
        if (key_ready !== e.kr) begin
          n_bad++;
          $display("FAIL %s key_ready: got %b want %b", e.name, key_ready, e.kr);
        end
      end
    end
  end

  logic [12:0] pool [8] = '{13'h0000, 13'h0040, 13'h0310, 13'h0314,
                            13'h1FFC, 13'h0800, 13'h0ABE, 13'h0FF0};

  initial begin
    reset = 1; ram_addr = 0; ram_write_enable = 0; ram_read_enable = 0;
    ram_byte_en = 0; ram_write_data = 0; key_valid = 0; key_data = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    step("rst_state", 0, 13'h0314, 0, 0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      step("init", 0, pool[i], 1, 0, 4'hF, $urandom, 0, 0);

    step("st_zero", 0, 13'h0040, 1, 0, 4'hF, 32'h0, 0, 0);
    step("st_lanes", 0, 13'h0040, 1, 0, 4'b0101, 32'hDEADBEEF, 0, 0,
         1, 32'h00AD00EF);
    step("ld_lanes", 0, 13'h0040, 0, 1, 4'h0, 0, 0, 0, 1, 32'h00AD00EF);
    step("be_zero", 0, 13'h0040, 1, 0, 4'h0, 32'hFFFFFFFF, 0, 0);
    step("ld_bez", 0, 13'h0043, 0, 0, 4'h0, 0, 0, 0, 1, 32'h00AD00EF);

`ifdef DATA_RAM_KEY_FIFO_EN
    step("push_A", 0, 13'h0040, 0, 0, 4'h0, 0, 1, 8'h41);
    step("push_B", 0, 13'h0040, 0, 0, 4'h0, 0, 1, 8'h42);
    step("stat_2", 0, 13'h0314, 0, 1, 4'h0, 0, 0, 0, 1, 32'h0200);
    step("pop_A", 0, 13'h0310, 0, 1, 4'h0, 0, 0, 0, 1, 32'h41);
    step("pop_B", 0, 13'h0310, 0, 1, 4'h0, 0, 0, 0, 1, 32'h42);
    step("stat_empty", 0, 13'h0314, 0, 0, 4'h0, 0, 0, 0, 1, 32'h1);
    step("pop_empty", 0, 13'h0310, 0, 1, 4'h0, 0, 0, 0, 1, 32'h0);
    for (int i = 0; i < 9; i++)
      step("fill", 0, 13'h0040, 0, 0, 4'h0, 0, 1, 8'h30 + 8'(i));
    step("stat_ovf", 0, 13'h0314, 0, 0, 4'h0, 0, 0, 0, 1, 32'h0806);
    step("ovf_clr", 0, 13'h0314, 1, 0, 4'h1, 32'h4, 0, 0);
    step("stat_clr", 0, 13'h0314, 0, 0, 4'h0, 0, 0, 0, 1, 32'h0802);
    step("full_pushpop", 0, 13'h0310, 0, 1, 4'h0, 0, 1, 8'h60, 1, 32'h30);
    step("stat_full", 0, 13'h0314, 0, 0, 4'h0, 0, 0, 0, 1, 32'h0802);
    step("ovf_setclr", 0, 13'h0314, 1, 0, 4'h1, 32'h4, 1, 8'h61);
    step("stat_setclr", 0, 13'h0314, 0, 0, 4'h0, 0, 0, 0, 1, 32'h0806);
    step("pop_31", 0, 13'h0310, 0, 1, 4'h0, 0, 0, 0, 1, 32'h31);
    repeat (7) step("drain", 0, 13'h0310, 0, 1, 4'h0, 0, 0, 0);
    step("pushpop_empty", 0, 13'h0310, 0, 1, 4'h0, 0, 1, 8'h5A, 1, 32'h0);
    step("stat_one", 0, 13'h0314, 0, 0, 4'h0, 0, 0, 0, 1, 32'h0104);
    step("clr2", 0, 13'h0314, 1, 0, 4'h1, 32'h4, 0, 0);
    repeat (3) step("push3", 0, 13'h0040, 0, 0, 4'h0, 0, 1, 8'h77);
    step("rst_push", 1, 13'h0310, 0, 1, 4'h0, 0, 1, 8'h78);
    step("stat_rst", 0, 13'h0314, 0, 0, 4'h0, 0, 0, 0, 1, 32'h1);
`else
    step("st_kd", 0, 13'h0310, 1, 0, 4'hF, 32'h12345678, 1, 8'h41);
    step("ld_kd", 0, 13'h0310, 0, 1, 4'h0, 0, 1, 8'h42, 1, 32'h12345678);
    step("st_ks", 0, 13'h0314, 1, 0, 4'hF, 32'h4, 0, 0);
    step("ld_ks", 0, 13'h0314, 0, 0, 4'h0, 0, 0, 0, 1, 32'h4);
    step("rst_x", 1, 13'h0040, 0, 0, 4'h0, 0, 1, 8'h43);
`endif
    step("ld_keep", 0, 13'h0040, 0, 1, 4'h0, 0, 0, 0, 1, 32'h00AD00EF);

    for (int i = 0; i < 400; i++) begin
      bit rst;
      bit w;
      rst = ($urandom_range(0, 49) == 0);
      w   = !rst && ($urandom_range(0, 2) == 0);
      step("rand", rst, pool[$urandom_range(0, 7)], w, 1'($urandom),
           4'($urandom), $urandom, 1'($urandom), 8'($urandom));
    end

    @(posedge clk);
    #1;
    chk = 0;
    reset = 0; ram_write_enable = 0; ram_read_enable = 0; key_valid = 0;
    repeat (2) @(posedge clk);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d entries want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_ram_mmio.md
DATA_RAM_MMIO -- requirements
Module: data_ram_mmio

Interface
REQ-001 Parameter ADDR_W, default 13, byte-address width.
REQ-002 Parameter DEPTH_WORDS, default 2048, number of 32-bit words; power of two, at most 2^(ADDR_W-2).
REQ-003 Parameter KEY_FIFO_DEPTH, default 8, keyboard FIFO entries; power of two, at least 2.
REQ-004 Parameter KEY_DATA_ADDR, default 13'h0310, byte address of the key-data port.
REQ-005 Parameter KEY_STAT_ADDR, default 13'h0314, byte address of the key-status port.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 ram_addr  in  ADDR_W  CPU byte address; bits [1:0] are ignored.
REQ-009 ram_write_enable  in  1  CPU store strobe.
REQ-010 ram_read_enable  in  1  CPU load strobe; qualifies FIFO pops.
REQ-011 ram_byte_en  in  4  per-lane store enable; bit i selects data bits [8i+7:8i].
REQ-012 ram_write_data  in  32  store data.
REQ-013 ram_read_data  out  32  load data, combinational.
REQ-014 key_data  in  8  ASCII code from the keyboard scanner.
REQ-015 key_valid  in  1  key_data is valid this cycle.
REQ-016 key_ready  out  1  FIFO not full; a key is accepted when key_valid && key_ready.

Function
REQ-017 Storage SHALL be word-indexed by ram_addr[ADDR_W-1:2] modulo DEPTH_WORDS, with no bounds fault.
REQ-018 A store SHALL update only the enabled byte lanes at the clock edge; ram_byte_en=0 SHALL leave memory unchanged.
REQ-019 A load SHALL return mem[word] combinationally; when ram_write_enable=1 it SHALL return the merged old/new word (write-through).
REQ-020 A load from KEY_DATA_ADDR SHALL return {24'h0, head} when the FIFO is non-empty and 32'h0 when it is empty; RAM SHALL NOT be accessed.
REQ-021 A pop SHALL occur at the edge when ram_read_enable=1, ram_addr==KEY_DATA_ADDR and the FIFO is non-empty; a pop from an empty FIFO SHALL be a no-op.
REQ-022 A load from KEY_STAT_ADDR SHALL return {16'h0, count[7:0], 5'h0, overflow, full, empty}.
REQ-023 A store to KEY_STAT_ADDR with byte lane 0 enabled and data bit 2 set SHALL clear overflow; all other stores to either key address SHALL be ignored.
REQ-024 A push with the FIFO full and no pop in the same cycle SHALL drop the key and set sticky overflow.
REQ-025 A simultaneous push and pop when full SHALL succeed on both sides, leaving count unchanged.
REQ-026 A simultaneous push and pop when empty SHALL complete the push only; the load SHALL return 32'h0.
REQ-027 Overflow set and clear in the same cycle SHALL resolve to set.
REQ-028 Read/write pointers SHALL wrap modulo KEY_FIFO_DEPTH; count SHALL range 0..KEY_FIFO_DEPTH.
REQ-029 Latency: a key pushed at edge N SHALL be readable combinationally from cycle N+1.

Reset
REQ-030 Reset SHALL clear the pointers, count and overflow, giving key_ready=1 and empty=1.
REQ-031 Reset SHALL NOT clear RAM contents; ram_read_data SHALL depend only on the address and stored data.
REQ-032 Reset asserted during a push or pop SHALL take priority and discard that operation.

Configuration
REQ-033 Macro DATA_RAM_KEY_FIFO_EN: when defined, the FIFO and both key ports SHALL exist as specified.
REQ-034 When DATA_RAM_KEY_FIFO_EN is undefined, both key addresses SHALL behave as ordinary RAM, key_ready SHALL be tied to 1, and key data SHALL be discarded.

Structure
REQ-035 Package data_ram_mmio_pkg SHALL hold the default key addresses, the status bit positions (EMPTY=0, FULL=1, OVF=2) and the status field layout.
REQ-036 The FIFO SHALL be a sub-module named key_fifo, with push/pop/head/count/full/empty ports.

Verification
REQ-037 Store 32'hDEADBEEF to 0x0040 with byte_en=4'b0101, over prior 32'h0 -> load 0x0040 returns 32'h00AD00EF.
REQ-038 Push 'A'(8'h41), then 'B' -> status reads count=2; two loads of 0x0310 with read_enable=1 return 32'h41 then 32'h42; status then shows empty=1.
REQ-039 Push 9 keys, depth 8, no pops -> key_ready=0 after 8 pushes, 9th key dropped, overflow=1; store 32'h4 to 0x0314 -> overflow=0.
REQ-040 FIFO full, push and pop in the same cycle -> count stays 8, and the popped value is the oldest key.
REQ-041 Reset after 3 pushes -> count=0, key_ready=1; a load of 0x0040 returns its pre-reset value.
REQ-042 Build without DATA_RAM_KEY_FIFO_EN: store 32'h12345678 to 0x0310 -> load 0x0310 returns 32'h12345678.
